// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM-stage load/store unit: writeback select,
// load/store funct3 codes and the LSU handshake state.
package riscv_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, extended
// load data and the misalignment / illegal-funct3 fault for one access.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_ld,
  input  logic        i_is_st,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_ext,
  output logic        o_fault
);

  logic        legal;
  logic        misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    legal    = 1'b0;
    misalign = 1'b0;
    o_be     = 4'b0000;
    o_wdata  = 32'd0;
    o_ld_ext = 32'd0;

    case (i_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~i_is_st;
      default:          legal = 1'b0;
    endcase

    // funct3[1:0] carries the access size for both signed and unsigned forms
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rs2_data[7:0]}};
      end
      2'b01: begin
        o_be     = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata  = {2{i_rs2_data[15:0]}};
        misalign = i_addr_lo[0];
      end
      2'b10: begin
        o_be     = 4'b1111;
        o_wdata  = i_rs2_data;
        misalign = |i_addr_lo;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'd0;
      end
    endcase

    if (!i_is_st) o_wdata = 32'd0;
    o_fault = (i_is_ld | i_is_st) & (~legal | misalign);

    ld_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    ld_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    o_ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    o_ld_ext = i_rdata;
      F3_BU:   o_ld_ext = {24'd0, ld_byte};
      F3_HU:   o_ld_ext = {16'd0, ld_half};
      default: o_ld_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: drives the data bus with a req/ack handshake and timeout,
// stalls the pipeline while an access is outstanding, feeds MEM/WB.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] MEM_i_alu_data,
  input  logic [31:0] MEM_i_rs2_data,
  input  logic [31:0] MEM_i_pc,
  input  logic        MEM_i_mem_wren,
  input  logic        MEM_i_reg_wren,
  input  logic [1:0]  MEM_i_wb_sel,
  input  logic [2:0]  MEM_i_funct_3,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  output logic        o_stall,
  output logic        o_access_fault,
  output logic        o_bus_err,
  output logic [31:0] WB_o_ld_data,
  output logic [31:0] WB_o_alu_data,
  output logic [31:0] WB_o_pc_four,
  output logic        WB_o_reg_wren,
  output logic [1:0]  WB_o_wb_sel
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_ld;
  logic        is_st;
  logic        fault;
  logic        acc;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_ext;

  assign is_ld = (MEM_i_wb_sel == WB_LOAD);
  assign is_st = MEM_i_mem_wren;

  lsu_align u_align (
    .i_funct3   (MEM_i_funct_3),
    .i_addr_lo  (MEM_i_alu_data[1:0]),
    .i_is_ld    (is_ld),
    .i_is_st    (is_st),
    .i_rs2_data (MEM_i_rs2_data),
    .i_rdata    (i_bus_rdata),
    .o_be       (al_be),
    .o_wdata    (al_wdata),
    .o_ld_ext   (al_ld_ext),
    .o_fault    (fault)
  );

  assign acc = (is_ld | is_st) & ~fault;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    ld_data_d = ld_data_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {MEM_i_alu_data[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // a late ack on the expiry cycle still completes the access
        if (i_bus_ack) begin
          ld_data_d = we_q ? 32'd0 : al_ld_ext;
          req_d     = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == TMO_LAST) begin
          ld_data_d = 32'd0;
          req_d     = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      ld_data_q <= 32'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_bus_req      = req_q;
  assign o_bus_we       = we_q;
  assign o_bus_addr     = addr_q;
  assign o_bus_be       = be_q;
  assign o_bus_wdata    = wdata_q;
  assign o_bus_err      = err_q;
  assign o_access_fault = fault;
  assign o_stall        = acc & (state_q != DONE);

  // faulted loads never reach the bus, so they complete with zero right away
  assign WB_o_ld_data  = (is_ld & fault) ? 32'd0 : ld_data_q;
  assign WB_o_alu_data = MEM_i_alu_data;
  assign WB_o_pc_four  = MEM_i_pc + 32'd4;
  assign WB_o_reg_wren = MEM_i_reg_wren;
  assign WB_o_wb_sel   = MEM_i_wb_sel;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the data-memory bus.
- Generates byte enables and store-data lanes, and sign/zero-extends load data.
- Runs a req/ack handshake with timeout, stalls the pipeline while an access is outstanding, and feeds the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for i_bus_ack before the access is aborted
- CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset; synchronous, active-low, sampled on rising i_clk
- MEM_i_alu_data  in  32  effective address, or ALU result
- MEM_i_rs2_data  in  32  store data
- MEM_i_pc  in  32  instruction PC
- MEM_i_mem_wren  in  1  store request
- MEM_i_reg_wren  in  1  register write enable, passed through
- MEM_i_wb_sel  in  2  00=ALU, 01=load, 10=PC+4; 01 marks a load
- MEM_i_funct_3  in  3  access size/sign
- i_bus_ack  in  1  memory completes access (one-cycle pulse)
- i_bus_rdata  in  32  read word, valid with ack
- o_bus_req  out  1  access request
- o_bus_we  out  1  1=write
- o_bus_addr  out  32  word address, {alu_data[31:2],2'b00}
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- o_stall  out  1  hold PC/IF/ID/EX and EX/MEM registers
- o_access_fault  out  1  misaligned address or illegal funct3 for the current access
- o_bus_err  out  1  one-cycle pulse on timeout
- WB_o_ld_data  out  32  extended load result (registered)
- WB_o_alu_data  out  32  pass-through of MEM_i_alu_data
- WB_o_pc_four  out  32  MEM_i_pc + 4, wraps mod 2^32
- WB_o_reg_wren  out  1  pass-through of MEM_i_reg_wren
- WB_o_wb_sel  out  2  pass-through of MEM_i_wb_sel

Behaviour:
- Definitions:
  - ld = (wb_sel==01); st = mem_wren.
  - acc = (ld|st) & ~o_access_fault.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 asserts o_access_fault.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, asserts o_access_fault. o_access_fault is combinational.
- Faulted accesses:
  - No bus request is issued and no stall is raised.
  - A faulted load delivers WB_o_ld_data=0 in the same cycle, via the DONE path bypass.
  - WB_o_reg_wren still passes through; the trap logic decides what to do with it.
- Byte enables and store data:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
  - Loads: be is generated the same way, wdata=0.
- Load extraction: select byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if acc, next state BUSY; o_bus_req, o_bus_we (=st), addr, be and wdata are registered into the bus outputs; counter cleared.
  - BUSY: bus outputs held stable; counter increments each cycle.
    - If i_bus_ack: capture the extended rdata into WB_o_ld_data (stores capture 0), drop req, go to DONE.
    - Else if counter==TIMEOUT_CYCLES-1: drop req, pulse o_bus_err, WB_o_ld_data=0, go to DONE.
  - DONE: one cycle; the pipeline advances at its end; next state IDLE unconditionally.
- o_stall = acc & (state!=DONE). This is combinational, so it is high in the IDLE cycle an access is first seen.
  - Minimum access latency: 3 cycles (IDLE, BUSY with ack, DONE).
- An ack arriving in IDLE or DONE is ignored. An ack in the same cycle as timeout expiry wins: data is captured, no error.
- Inputs are held stable by the stall. Their values are not re-sampled during BUSY.
- Reset (i_reset_n=0 at posedge, including mid-access):
  - state=IDLE, o_bus_req=0, o_bus_we=0, o_bus_addr=0, o_bus_be=0, o_bus_wdata=0, o_bus_err=0, WB_o_ld_data=0, counter=0.
  - The pending access is abandoned.
  - Combinational outputs follow their inputs.

Decomposition:
- Shared package riscv_pkg:
  - wb_sel encodings WB_ALU/WB_LOAD/WB_PC4.
  - funct3 constants F3_B/H/W/BU/HU.
  - lsu_state_e enum {IDLE,BUSY,DONE}.
- One combinational sub-module, lsu_align: funct3 and addr[1:0] in; be, lane wdata, extended load data and fault out.
- The FSM, timeout counter and registers stay in mem_stage_lsu.

Test Plan:
- SW addr=0x100, rs2=0xDEADBEEF, ack after 2 BUSY cycles:
  - In BUSY: req=1, we=1, addr=0x100, be=1111, wdata=0xDEADBEEF.
  - o_stall high for 3 cycles, low in DONE.
- LB addr=0x103, rdata=0x80FF_0000 -> WB_o_ld_data=0xFFFFFF80. LBU at the same address with the same data -> 0x00000080. Both use be=1000.
- SH addr=0x202, rs2=0x1234ABCD -> be=1100, wdata=0xABCDABCD. LH addr=0x201 -> o_access_fault=1, no req, o_stall=0, WB_o_ld_data=0.
- LW with ack never asserted, TIMEOUT_CYCLES=4 -> req drops after 4 BUSY cycles, o_bus_err pulses once, WB_o_ld_data=0, then DONE, then IDLE.
- Reset asserted in the second BUSY cycle -> next cycle state=IDLE, req=0, o_stall=0; a later ack is ignored.
- Back-to-back LW at 0x10 then SW at 0x14, each acked on the first BUSY cycle -> two 3-cycle sequences with no idle gap beyond DONE. pc=0xFFFFFFFC -> WB_o_pc_four=0x00000000.
